// File: rtl/csr_regfile_pkg.sv
// ============================================================================
// csr_regfile_pkg : CSR indices, field positions, exception codes, write masks
// Revision: 1.0
// ============================================================================
`default_nettype none

package csr_regfile_pkg;

   localparam logic [13:0] c_CSR_CRMD   = 14'h000;
   localparam logic [13:0] c_CSR_PRMD   = 14'h001;
   localparam logic [13:0] c_CSR_ECFG   = 14'h004;
   localparam logic [13:0] c_CSR_ESTAT  = 14'h005;
   localparam logic [13:0] c_CSR_ERA    = 14'h006;
   localparam logic [13:0] c_CSR_BADV   = 14'h007;
   localparam logic [13:0] c_CSR_EENTRY = 14'h00C;
   localparam logic [13:0] c_CSR_SAVE0  = 14'h030;
   localparam logic [13:0] c_CSR_TID    = 14'h040;
   localparam logic [13:0] c_CSR_TCFG   = 14'h041;
   localparam logic [13:0] c_CSR_TVAL   = 14'h042;
   localparam logic [13:0] c_CSR_TICLR  = 14'h044;

   localparam int c_CRMD_PLV      = 0;
   localparam int c_CRMD_IE       = 2;
   localparam int c_CRMD_DA       = 3;
   localparam int c_CRMD_PG       = 4;
   localparam int c_PRMD_PPLV     = 0;
   localparam int c_PRMD_PIE      = 2;
   localparam int c_ESTAT_IS_HW   = 2;
   localparam int c_ESTAT_IS_TI   = 11;
   localparam int c_ESTAT_IS_IPI  = 12;
   localparam int c_ESTAT_ECODE   = 16;
   localparam int c_ESTAT_ESUB    = 22;
   localparam int c_TCFG_EN       = 0;
   localparam int c_TCFG_PERIODIC = 1;
   localparam int c_TCFG_INITVAL  = 2;

   localparam logic [5:0] c_ECODE_INT = 6'h00;
   localparam logic [5:0] c_ECODE_ADE = 6'h08;
   localparam logic [5:0] c_ECODE_ALE = 6'h09;
   localparam logic [5:0] c_ECODE_SYS = 6'h0B;
   localparam logic [5:0] c_ECODE_BRK = 6'h0C;
   localparam logic [5:0] c_ECODE_INE = 6'h0D;
   localparam logic [8:0] c_ESUBCODE_ADEF = 9'h000;

   localparam logic [31:0] c_CRMD_RESET   = 32'h1 << c_CRMD_DA;
   localparam logic [31:0] c_CRMD_WMASK   = (32'h1 << (c_CRMD_PG + 1)) - 32'h1;
   localparam logic [31:0] c_PRMD_WMASK   = 32'h0000_0007;
   localparam logic [31:0] c_ECFG_WMASK   = 32'h0000_1BFF;
   localparam logic [31:0] c_ESTAT_WMASK  = 32'h0000_0003;
   localparam logic [31:0] c_EENTRY_WMASK = 32'hFFFF_FFC0;

   function automatic logic [31:0] csr_wmerge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
      return (old_val & ~mask) | (new_val & mask);
   endfunction

endpackage

`default_nettype wire

// File: rtl/csr_regfile_if.sv
// ============================================================================
// csr_regfile_if : pipeline <-> CSR register file signal bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface csr_regfile_if;
   logic [13:0] csr_num;
   logic [31:0] csr_rvalue;
   logic        csr_we;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wvalue;
   logic        wb_ex;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc;
   logic [31:0] wb_vaddr;
   logic        ertn_flush;
   logic [7:0]  hw_int_in;
   logic        ipi_int_in;
   logic [31:0] ex_entry;
   logic [31:0] ertn_entry;
   logic        has_int;

   modport master (
      output csr_num, csr_we, csr_wmask, csr_wvalue, wb_ex, wb_ecode, wb_esubcode,
             wb_pc, wb_vaddr, ertn_flush, hw_int_in, ipi_int_in,
      input  csr_rvalue, ex_entry, ertn_entry, has_int
   );

   modport slave (
      input  csr_num, csr_we, csr_wmask, csr_wvalue, wb_ex, wb_ecode, wb_esubcode,
             wb_pc, wb_vaddr, ertn_flush, hw_int_in, ipi_int_in,
      output csr_rvalue, ex_entry, ertn_entry, has_int
   );
endinterface

`default_nettype wire

// File: rtl/csr_regfile_timer.sv
// ============================================================================
// csr_timer : TCFG/TVAL countdown timer with TICLR-cleared interrupt flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module csr_timer
   import csr_regfile_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we_i,
   input  logic [13:0] num_i,
   input  logic [31:0] wmask_i,
   input  logic [31:0] wvalue_i,
   output logic [31:0] tcfg_o,
   output logic [31:0] tval_o,
   output logic        ti_o
);
   logic [31:0] tcfg_q, tcfg_d;
   logic [31:0] tval_q, tval_d;
   logic        ti_q, ti_d;

   always_comb begin
      tcfg_d = tcfg_q;
      tval_d = tval_q;
      ti_d   = ti_q;
      if (we_i && num_i == c_CSR_TICLR && wmask_i[0] && wvalue_i[0]) begin
         ti_d = 1'b0;
      end
      // A TCFG write preempts counting; the expiry set below overrides a clear.
      if (we_i && num_i == c_CSR_TCFG) begin
         tcfg_d = csr_wmerge(tcfg_q, wvalue_i, wmask_i);
         if (tcfg_d[c_TCFG_EN]) begin
            tval_d = {tcfg_d[31:c_TCFG_INITVAL], 2'b00};
         end
      end else if (tcfg_q[c_TCFG_EN]) begin
         if (tval_q != 32'd0) begin
            tval_d = tval_q - 32'd1;
            if (tval_q == 32'd1) begin
               ti_d = 1'b1;
            end
         end else if (tcfg_q[c_TCFG_PERIODIC]) begin
            tval_d = {tcfg_q[31:c_TCFG_INITVAL], 2'b00};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tcfg_q <= '0;
         tval_q <= '0;
         ti_q   <= 1'b0;
      end else begin
         tcfg_q <= tcfg_d;
         tval_q <= tval_d;
         ti_q   <= ti_d;
      end
   end

   assign tcfg_o = tcfg_q;
   assign tval_o = tval_q;
   assign ti_o   = ti_q;

endmodule

`default_nettype wire

// File: rtl/csr_regfile.sv
// ============================================================================
// csr_regfile : exception/status CSRs, redirect targets and interrupt pending.
// Timer CSRs (TID/TCFG/TVAL/TICLR) exist only when CSR_TIMER_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module csr_regfile
   import csr_regfile_pkg::*;
#(
   parameter logic [31:0] COREID   = 32'h0,
   parameter int          SAVE_NUM = 4
) (
   input  logic         clk,
   input  logic         reset,
   csr_regfile_if.slave bus
);
   logic [31:0] crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d;
   logic [31:0] estat_q, estat_d, era_q, era_d, badv_q, badv_d;
   logic [31:0] eentry_q, eentry_d;
   logic [31:0] save_q [SAVE_NUM];
   logic [31:0] save_d [SAVE_NUM];
   logic [31:0] w_estat, w_rdata;
   logic        w_we, w_ti;

   assign w_we = bus.csr_we & ~bus.wb_ex & ~bus.ertn_flush;

   always_comb begin
      crmd_d   = crmd_q;
      prmd_d   = prmd_q;
      ecfg_d   = ecfg_q;
      estat_d  = estat_q;
      era_d    = era_q;
      badv_d   = badv_q;
      eentry_d = eentry_q;
      if (bus.wb_ex) begin
         prmd_d[c_PRMD_PPLV +: 2] = crmd_q[c_CRMD_PLV +: 2];
         prmd_d[c_PRMD_PIE]       = crmd_q[c_CRMD_IE];
         crmd_d[c_CRMD_PLV +: 2]  = 2'b00;
         crmd_d[c_CRMD_IE]        = 1'b0;
         era_d                    = bus.wb_pc;
         estat_d[c_ESTAT_ECODE +: 6] = bus.wb_ecode;
         estat_d[c_ESTAT_ESUB +: 9]  = bus.wb_esubcode;
         if (bus.wb_ecode == c_ECODE_ADE) begin
            badv_d = bus.wb_pc;
         end else if (bus.wb_ecode == c_ECODE_ALE) begin
            badv_d = bus.wb_vaddr;
         end
      end else if (bus.ertn_flush) begin
         crmd_d[c_CRMD_PLV +: 2] = prmd_q[c_PRMD_PPLV +: 2];
         crmd_d[c_CRMD_IE]       = prmd_q[c_PRMD_PIE];
      end else if (w_we) begin
         case (bus.csr_num)
            c_CSR_CRMD:   crmd_d   = csr_wmerge(crmd_q, bus.csr_wvalue, bus.csr_wmask & c_CRMD_WMASK);
            c_CSR_PRMD:   prmd_d   = csr_wmerge(prmd_q, bus.csr_wvalue, bus.csr_wmask & c_PRMD_WMASK);
            c_CSR_ECFG:   ecfg_d   = csr_wmerge(ecfg_q, bus.csr_wvalue, bus.csr_wmask & c_ECFG_WMASK);
            c_CSR_ESTAT:  estat_d  = csr_wmerge(estat_q, bus.csr_wvalue, bus.csr_wmask & c_ESTAT_WMASK);
            c_CSR_ERA:    era_d    = csr_wmerge(era_q, bus.csr_wvalue, bus.csr_wmask);
            c_CSR_EENTRY: eentry_d = csr_wmerge(eentry_q, bus.csr_wvalue, bus.csr_wmask & c_EENTRY_WMASK);
            default: ;
         endcase
      end
      // Interrupt lines are level-sampled every cycle regardless of commits.
      estat_d[c_ESTAT_IS_HW +: 8] = bus.hw_int_in;
      estat_d[c_ESTAT_IS_IPI]     = bus.ipi_int_in;
   end

   always_comb begin
      for (int i = 0; i < SAVE_NUM; i++) begin
         save_d[i] = save_q[i];
         if (w_we && bus.csr_num == c_CSR_SAVE0 + 14'(i)) begin
            save_d[i] = csr_wmerge(save_q[i], bus.csr_wvalue, bus.csr_wmask);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         crmd_q   <= c_CRMD_RESET;
         prmd_q   <= '0;
         ecfg_q   <= '0;
         estat_q  <= '0;
         era_q    <= '0;
         badv_q   <= '0;
         eentry_q <= '0;
         for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= '0;
      end else begin
         crmd_q   <= crmd_d;
         prmd_q   <= prmd_d;
         ecfg_q   <= ecfg_d;
         estat_q  <= estat_d;
         era_q    <= era_d;
         badv_q   <= badv_d;
         eentry_q <= eentry_d;
         for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= save_d[i];
      end
   end

`ifdef CSR_TIMER_EN
   logic [31:0] tid_q, tid_d, w_tcfg, w_tval;

   assign tid_d = (w_we && bus.csr_num == c_CSR_TID)
                  ? csr_wmerge(tid_q, bus.csr_wvalue, bus.csr_wmask) : tid_q;

   always_ff @(posedge clk) begin
      if (reset) tid_q <= COREID;
      else       tid_q <= tid_d;
   end

   csr_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .we_i     (w_we),
      .num_i    (bus.csr_num),
      .wmask_i  (bus.csr_wmask),
      .wvalue_i (bus.csr_wvalue),
      .tcfg_o   (w_tcfg),
      .tval_o   (w_tval),
      .ti_o     (w_ti)
   );
`else
   assign w_ti = 1'b0;
`endif

   // estat_q[11] is never set; the timer flag lives in the timer block.
   assign w_estat = estat_q | ({31'b0, w_ti} << c_ESTAT_IS_TI);

   always_comb begin
      w_rdata = '0;
      case (bus.csr_num)
         c_CSR_CRMD:   w_rdata = crmd_q;
         c_CSR_PRMD:   w_rdata = prmd_q;
         c_CSR_ECFG:   w_rdata = ecfg_q;
         c_CSR_ESTAT:  w_rdata = w_estat;
         c_CSR_ERA:    w_rdata = era_q;
         c_CSR_BADV:   w_rdata = badv_q;
         c_CSR_EENTRY: w_rdata = eentry_q;
`ifdef CSR_TIMER_EN
         c_CSR_TID:    w_rdata = tid_q;
         c_CSR_TCFG:   w_rdata = w_tcfg;
         c_CSR_TVAL:   w_rdata = w_tval;
`endif
         default: begin
            for (int i = 0; i < SAVE_NUM; i++) begin
               if (bus.csr_num == c_CSR_SAVE0 + 14'(i)) w_rdata = save_q[i];
            end
         end
      endcase
   end

   assign bus.csr_rvalue = w_rdata;
   assign bus.ex_entry   = eentry_q;
   assign bus.ertn_entry = era_q;
   assign bus.has_int    = crmd_q[c_CRMD_IE] & (|(w_estat[12:0] & ecfg_q[12:0]));

endmodule

`default_nettype wire

// File: tb/tb_csr_regfile.sv
// ============================================================================
// tb_csr_regfile : directed + random stimulus against a table-driven CSR model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_csr_regfile;
   localparam logic [31:0] COREID   = 32'h0000_00A5;
   localparam int          SAVE_NUM = 4;
`ifdef CSR_TIMER_EN
   localparam bit TIMER = 1'b1;
`else
   localparam bit TIMER = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   csr_regfile_if bus ();

   csr_regfile #(.COREID(COREID), .SAVE_NUM(SAVE_NUM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Reference model: CSR contents keyed by CSR number; ESTAT kept as fields.
   logic [31:0] mreg [int];
   logic [1:0]  m_sw;
   logic [5:0]  m_ecode;
   logic [8:0]  m_esub;
   logic [7:0]  m_hw;
   logic        m_ipi, m_ti;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } exp_t;
   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   bit   chk_en = 1'b0;

   function automatic logic [31:0] soft_mask(int n);
      if (n == 'h00) return 32'h0000_001F;
      if (n == 'h01) return 32'h0000_0007;
      if (n == 'h04) return 32'h0000_1BFF;
      if (n == 'h06) return 32'hFFFF_FFFF;
      if (n == 'h0C) return 32'hFFFF_FFC0;
      if (n >= 'h30 && n < 'h30 + SAVE_NUM) return 32'hFFFF_FFFF;
      if (TIMER && (n == 'h40 || n == 'h41)) return 32'hFFFF_FFFF;
      return 32'h0;
   endfunction

   function automatic logic [31:0] m_read(int n);
      if (n == 'h05) return {1'b0, m_esub, m_ecode, 3'b000, m_ipi, m_ti, 1'b0, m_hw, m_sw};
      if (mreg.exists(n)) return mreg[n];
      return 32'h0;
   endfunction

   function automatic bit m_has_int();
      logic [31:0] crmd;
      crmd = mreg['h00];
      return crmd[2] && ((m_read('h05) & mreg['h04] & 32'h1FFF) != 32'h0);
   endfunction

   task automatic m_reset();
      mreg.delete();
      mreg['h00] = 32'h8;
      mreg['h01] = 0; mreg['h04] = 0; mreg['h06] = 0; mreg['h07] = 0; mreg['h0C] = 0;
      for (int i = 0; i < SAVE_NUM; i++) mreg['h30 + i] = 0;
      if (TIMER) begin
         mreg['h40] = COREID; mreg['h41] = 0; mreg['h42] = 0;
      end
      m_sw = 0; m_ecode = 0; m_esub = 0; m_hw = 0; m_ipi = 0; m_ti = 0;
   endtask

   task automatic m_step();
      logic [31:0] nx [int];
      logic [31:0] wm, wv, sm, tcfg, tval, t;
      logic [1:0]  sw_n;
      logic [5:0]  ecode_n;
      logic [8:0]  esub_n;
      logic        ti_n;
      int          n;
      bit          we;
      if (reset) begin
         m_reset();
         return;
      end
      nx = mreg;
      n  = int'(bus.csr_num);
      wm = bus.csr_wmask;
      wv = bus.csr_wvalue;
      we = bus.csr_we && !bus.wb_ex && !bus.ertn_flush;
      sw_n = m_sw; ecode_n = m_ecode; esub_n = m_esub; ti_n = m_ti;
      if (we && n == 'h05) begin
         sw_n = (m_sw & ~wm[1:0]) | (wv[1:0] & wm[1:0]);
      end else if (we && mreg.exists(n)) begin
         sm = wm & soft_mask(n);
         nx[n] = (mreg[n] & ~sm) | (wv & sm);
      end
      if (TIMER) begin
         tcfg = mreg['h41];
         tval = mreg['h42];
         if (we && n == 'h44 && wm[0] && wv[0]) ti_n = 1'b0;
         if (we && n == 'h41) begin
            t = nx['h41];
            if (t[0]) nx['h42] = t & ~32'h3;
         end else if (tcfg[0]) begin
            if (tval != 0) begin
               nx['h42] = tval - 1;
               if (tval == 1) ti_n = 1'b1;
            end else if (tcfg[1]) begin
               nx['h42] = tcfg & ~32'h3;
            end
         end
      end
      if (bus.wb_ex) begin
         nx['h01] = (mreg['h01] & ~32'h7) | (mreg['h00] & 32'h7);
         nx['h00] = mreg['h00] & ~32'h7;
         nx['h06] = bus.wb_pc;
         ecode_n  = bus.wb_ecode;
         esub_n   = bus.wb_esubcode;
         if (bus.wb_ecode == 6'h08)      nx['h07] = bus.wb_pc;
         else if (bus.wb_ecode == 6'h09) nx['h07] = bus.wb_vaddr;
      end else if (bus.ertn_flush) begin
         nx['h00] = (mreg['h00] & ~32'h7) | (mreg['h01] & 32'h7);
      end
      mreg = nx;
      m_sw = sw_n; m_ecode = ecode_n; m_esub = esub_n; m_ti = ti_n;
      m_hw = bus.hw_int_in; m_ipi = bus.ipi_int_in;
   endtask

   task automatic push(string name, int kind, logic [31:0] exp);
      exp_t e;
      e.name = name; e.kind = kind; e.exp = exp;
      q.push_back(e);
   endtask

   task automatic expect_rd(string name, logic [31:0] exp);
      push(name, 0, exp);
   endtask

   task automatic expect_int(string name, bit exp);
      push(name, 1, {31'b0, exp});
   endtask

   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      if (chk_en) begin
         if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL monitor: got no queued expectation, required at least one");
         end
         while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
               0:       act = bus.csr_rvalue;
               1:       act = {31'b0, bus.has_int};
               2:       act = bus.ex_entry;
               default: act = bus.ertn_entry;
            endcase
            total++;
            if (act !== e.exp) begin
               bad++;
               $display("FAIL %s (csr 0x%0h): got %h required %h", e.name, bus.csr_num, act, e.exp);
            end
         end
      end
   end

   task automatic cycle();
      if (!reset) begin
         push("model_rdata", 0, m_read(int'(bus.csr_num)));
         push("model_has_int", 1, {31'b0, m_has_int()});
         push("model_ex_entry", 2, mreg['h0C]);
         push("model_ertn_entry", 3, mreg['h06]);
         chk_en = 1'b1;
      end
      m_step();
      @(posedge clk);
      #1;
      chk_en = 1'b0;
   endtask

   task automatic idle();
      bus.csr_we = 0; bus.csr_wmask = 0; bus.csr_wvalue = 0;
      bus.wb_ex = 0; bus.wb_ecode = 0; bus.wb_esubcode = 0;
      bus.wb_pc = 0; bus.wb_vaddr = 0; bus.ertn_flush = 0;
   endtask

   task automatic wr(logic [13:0] num, logic [31:0] mask, logic [31:0] val);
      bus.csr_we = 1; bus.csr_num = num; bus.csr_wmask = mask; bus.csr_wvalue = val;
   endtask

   task automatic rd(logic [13:0] num, string name, logic [31:0] exp);
      idle();
      bus.csr_num = num;
      expect_rd(name, exp);
      cycle();
   endtask

   task automatic except(logic [5:0] ecode, logic [31:0] pc, logic [31:0] vaddr);
      bus.wb_ex = 1; bus.wb_ecode = ecode; bus.wb_esubcode = 0;
      bus.wb_pc = pc; bus.wb_vaddr = vaddr;
   endtask

   logic [13:0] nums [18] = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0C,
                              14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41, 14'h42,
                              14'h44, 14'h43, 14'h02, 14'h34};

   initial begin
      idle();
      bus.csr_num = 0; bus.hw_int_in = 0; bus.ipi_int_in = 0;
      reset = 1;
      @(posedge clk); #1;
      cycle();
      cycle();
      reset = 0;

      // Reset state
      bus.csr_num = 'h00; expect_rd("reset_crmd", 32'h8); expect_int("reset_has_int", 0); cycle();
      rd('h05, "reset_estat", 32'h0);
      rd('h43, "unimpl_0x43", 32'h0);
      rd('h40, "reset_tid", TIMER ? COREID : 32'h0);

      // Masked write to SAVE0
      wr('h30, 32'hFFFF_0000, 32'h1234_5678); cycle();
      rd('h30, "save0_masked", 32'h1234_0000);

      // Exception (ALE) entry
      idle(); wr('h00, 32'hFFFF_FFFF, 32'hF); cycle();
      idle(); except(6'h09, 32'h1C00_0100, 32'h0000_1003); cycle();
      rd('h00, "ex_crmd", 32'h8);
      rd('h01, "ex_prmd", 32'h7);
      rd('h06, "ex_era", 32'h1C00_0100);
      rd('h05, "ex_estat", 32'h0009_0000);
      rd('h07, "ex_badv_ale", 32'h0000_1003);

      // ERTN, then exception overriding a same-cycle CRMD write
      idle(); bus.ertn_flush = 1; cycle();
      rd('h00, "ertn_crmd", 32'hF);
      idle(); wr('h00, 32'hFFFF_FFFF, 32'h0); except(6'h0B, 32'h1C00_0200, 32'h0); cycle();
      rd('h00, "ex_over_we_crmd", 32'h8);
      rd('h01, "ex_over_we_prmd", 32'h7);
      rd('h07, "badv_kept_sys", 32'h0000_1003);

`ifdef CSR_TIMER_EN
      idle(); wr('h41, 32'hFFFF_FFFF, 32'h0000_000B); cycle();
      for (int k = 1; k <= 9; k++) rd('h42, "tval_count", 32'(9 - k));
      rd('h42, "tval_reload", 32'h8);
      rd('h05, "estat_timer_set", 32'h000B_0800);
      idle(); wr('h04, 32'hFFFF_FFFF, 32'h800); cycle();
      idle(); wr('h00, 32'hFFFF_FFFF, 32'hC); cycle();
      idle(); expect_int("timer_has_int", 1); cycle();
      idle(); wr('h44, 32'hFFFF_FFFF, 32'h1); cycle();
      idle(); bus.csr_num = 'h05; expect_rd("ticlr_estat", 32'h000B_0000);
      expect_int("ticlr_has_int", 0); cycle();
      idle(); wr('h41, 32'hFFFF_FFFF, 32'h0); cycle();
      rd('h44, "ticlr_reads_0", 32'h0);
`else
      idle(); wr('h41, 32'hFFFF_FFFF, 32'h0000_000B); cycle();
      rd('h41, "no_timer_tcfg", 32'h0);
      rd('h42, "no_timer_tval", 32'h0);
      idle(); wr('h04, 32'hFFFF_FFFF, 32'h800); cycle();
      idle(); wr('h00, 32'hFFFF_FFFF, 32'hC); cycle();
      rd('h05, "no_timer_estat", 32'h000B_0000);
`endif

      // Hardware interrupt path
      idle(); wr('h04, 32'hFFFF_FFFF, 32'h4); cycle();
      idle(); bus.hw_int_in = 8'h01; expect_int("hw_before_sample", 0); cycle();
      idle(); expect_int("hw_has_int", 1); cycle();
      idle(); wr('h00, 32'hFFFF_FFFF, 32'h8); cycle();
      idle(); expect_int("ie_cleared", 0); cycle();
      bus.hw_int_in = 0;

      // ADE takes the PC as BADV
      idle(); except(6'h08, 32'h1C00_0300, 32'hDEAD_BEEF); cycle();
      rd('h07, "ex_badv_ade", 32'h1C00_0300);

      // Randomized traffic
      for (int it = 0; it < 3000; it++) begin
         idle();
         reset = ($urandom_range(0, 499) == 0);
         bus.hw_int_in  = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : bus.hw_int_in;
         bus.ipi_int_in = ($urandom_range(0, 7) == 0) ? ~bus.ipi_int_in : bus.ipi_int_in;
         bus.csr_num    = nums[$urandom_range(0, 17)];
         if ($urandom_range(0, 1) == 1) begin
            bus.csr_we     = 1;
            bus.csr_wmask  = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom();
            bus.csr_wvalue = (bus.csr_num == 'h41) ? 32'($urandom_range(0, 40)) : $urandom();
         end
         if ($urandom_range(0, 9) == 0) begin
            bus.wb_ex       = 1;
            bus.wb_ecode    = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(8, 9)) : 6'($urandom());
            bus.wb_esubcode = 9'($urandom());
            bus.wb_pc       = $urandom();
            bus.wb_vaddr    = $urandom();
         end else if ($urandom_range(0, 9) == 0) begin
            bus.ertn_flush = 1;
         end
         cycle();
      end
      reset = 0;
      idle();

      @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d unchecked expectations, required 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Control/status register file; sits directly downstream of the mm2-stage CSR controller.
- Consumes the committed CSR write enable, exception ecode/esubcode, exception PC and bad vaddr.
- Holds CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0-3 and the timer CSRs.
- Produces the CSR read data, exception/ERTN redirect targets and the interrupt-pending signal fed back to the pipeline.

Parameters:
- COREID, 32'h0, reset value of TID.
- SAVE_NUM, 4, number of SAVEn scratch registers, 1..4, CSR 0x30+n.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- csr_num  in  14  CSR index for read and write.
- csr_rvalue  out  32  combinational read data for csr_num; unimplemented index reads 0.
- csr_we  in  1  committed CSR write, from mm2_csr_we.
- csr_wmask  in  32  bit mask; 1 = bit written.
- csr_wvalue  in  32  write data.
- wb_ex  in  1  exception commit this cycle.
- wb_ecode  in  6  from mm2_ecode.
- wb_esubcode  in  9  from mm2_esubcode.
- wb_pc  in  32  PC of the excepting instruction.
- wb_vaddr  in  32  faulting address, used for ADE/ALE.
- ertn_flush  in  1  ERTN commit this cycle.
- hw_int_in  in  8  level hardware interrupts, sampled into ESTAT.IS[9:2].
- ipi_int_in  in  1  IPI, sampled into ESTAT.IS[12].
- ex_entry  out  32  EENTRY value (exception target).
- ertn_entry  out  32  ERA value (ERTN target).
- has_int  out  1  interrupt pending and enabled.

Behaviour:
- Reset (sync, active-high) sets:
  - CRMD = 32'h8 (DA=1, PLV=0, IE=0).
  - PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVEn = 0.
  - TCFG.En = 0, TVAL = 0, TID = COREID.
  - Outputs then show: ex_entry = 0, ertn_entry = 0, has_int = 0.
- Reads are combinational, zero latency, from current register state.
- Writes take effect at the next posedge: `reg <= (reg & ~wmask) | (wvalue & wmask)`, restricted to the writable fields of that CSR.
- Read-only fields ignore writes:
  - ESTAT: only IS[1:0] is software-writable.
  - BADV and TVAL are read-only to software.
- Writable fields:
  - CRMD: PLV[1:0], IE[2], DA[3], PG[4].
  - PRMD: PPLV[1:0], PIE[2].
  - ECFG: LIE[12:0] with bit 10 forced 0.
  - EENTRY: VA[31:6], low bits 0.
- Exception commit (wb_ex=1) at posedge:
  - PRMD.PPLV <= CRMD.PLV; PRMD.PIE <= CRMD.IE.
  - CRMD.PLV <= 0; CRMD.IE <= 0.
  - ERA <= wb_pc.
  - ESTAT.Ecode[21:16] <= wb_ecode; ESTAT.EsubCode[30:22] <= wb_esubcode.
  - BADV <= wb_vaddr iff wb_ecode is ADE (6'h08) or ALE (6'h09); for ADE, BADV <= wb_pc.
- ERTN commit (ertn_flush=1): CRMD.PLV <= PRMD.PPLV; CRMD.IE <= PRMD.PIE.
- Priority within one cycle: wb_ex > ertn_flush > csr_we.
  - The upstream controller already zeroes csr_we on exception; wb_ex still suppresses csr_we defensively.
- Interrupt sampling: ESTAT.IS[9:2] <= hw_int_in and IS[12] <= ipi_int_in, every cycle.
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]); combinational.
- Timer:
  - Any TCFG write with new En=1 loads TVAL <= {InitVal[31:2], 2'b00}.
  - While En=1 and TVAL != 0: TVAL decrements by 1 per cycle.
  - On the TVAL 1->0 transition, set ESTAT.IS[11].
  - At 0: if Periodic=1, reload InitVal next cycle; else TVAL holds 0 and no further interrupts.
  - Writing TICLR with bit0=1 clears IS[11]. TICLR always reads 0.
  - Same-cycle timer set and TICLR clear: set wins.
  - TCFG.En=0 mid-count freezes TVAL.
- CSR numbers: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.

Optional Feature:
- Macro: CSR_TIMER_EN.
- Defined: TID/TCFG/TVAL/TICLR and timer interrupt implemented as above.
- Undefined: no timer logic; TID/TCFG/TVAL/TICLR read 0 and ignore writes; ESTAT.IS[11] constant 0.

Decomposition:
- Shared defs header gains: CSR index constants, CRMD/PRMD/ESTAT/TCFG field bit positions, ECODE values (INT 0x0, ADE 0x8, ALE 0x9, SYS 0xB, BRK 0xC, INE 0xD), ESUBCODE_ADEF 0.
- Sub-module: csr_timer (TCFG, TVAL, TICLR, timer-interrupt flag), instantiated under CSR_TIMER_EN.

Test Plan:
- Reset, then read 0x0 -> 32'h8; read 0x5 -> 0; has_int=0; read 0x43 (unimplemented) -> 0.
- csr_we, num 0x30, wmask 32'hFFFF0000, wvalue 32'h12345678 over 0 -> read 32'h12340000 next cycle.
- CRMD.PLV=3, IE=1; wb_ex, ecode 0x9, pc 32'h1c000100, vaddr 32'h1003 ->
  - CRMD.PLV=0, IE=0; PRMD=32'h7.
  - ERA=32'h1c000100; ESTAT[21:16]=0x9; BADV=32'h1003.
- Then ertn_flush=1 -> CRMD.PLV=3, IE=1. Same cycle wb_ex=1 and csr_we to CRMD -> exception update only, write dropped.
- TCFG write 32'h0000_000B (InitVal=8, Periodic=1, En=1) ->
  - TVAL=8, counts to 0 in 8 cycles; IS[11]=1.
  - TVAL reloads 8.
  - With LIE[11]=1 and IE=1: has_int=1. TICLR write 1 -> IS[11]=0.
- hw_int_in=8'h01, LIE=13'h004, IE=1 -> has_int=1 one cycle after assertion. Clear IE -> has_int=0.
